// File: rtl/controle_pc_pkg.sv
// pacote_processador: shared widths and PC-unit state encodings
package pacote_processador;
  localparam int PC_ADDR_WIDTH = 13;
  localparam int PC_DATA_WIDTH = 32;
  localparam logic [1:0] EST_RUN = 2'd0;
  localparam logic [1:0] EST_HALT = 2'd1;
  localparam logic [1:0] EST_ISR = 2'd2;
endpackage

// File: rtl/controle_pc_if.sv
// controle_pc_if: control-unit to PC-unit bus (master drives requests, slave is the PC unit)
interface controle_pc_if
  import pacote_processador::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int DATA_WIDTH = PC_DATA_WIDTH
);
  logic                  stall;
  logic                  halt;
  logic                  resume;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  jalr;
  logic                  j_reg;
  logic [DATA_WIDTH-1:0] dado1;
  logic                  irq;
  logic                  reti;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_link;
  logic [ADDR_WIDTH-1:0] epc;
  logic [1:0]            estado;
  logic                  irq_ack;
  modport master (
    output stall, halt, resume, branch_taken, branch_target, jump, jump_addr,
           jalr, j_reg, dado1, irq, reti,
    input  pc, pc_link, epc, estado, irq_ack
  );
  modport slave (
    input  stall, halt, resume, branch_taken, branch_target, jump, jump_addr,
           jalr, j_reg, dado1, irq, reti,
    output pc, pc_link, epc, estado, irq_ack
  );
endinterface

// File: rtl/controle_pc_seletor_destino.sv
// seletor_destino: priority mux for the sequential next PC (register jump > jump > branch > pc+1)
module seletor_destino
  import pacote_processador::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int DATA_WIDTH = PC_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jalr,
  input  logic                  j_reg,
  input  logic [DATA_WIDTH-1:0] dado1,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] next_seq
);
  logic unused_dado1;
  assign unused_dado1 = ^dado1[DATA_WIDTH-1:ADDR_WIDTH];
  // register jumps keep only the address bits of the operand
  always_comb
    next_seq = (jalr | j_reg) ? dado1[ADDR_WIDTH-1:0] :
               jump           ? jump_addr :
               branch_taken   ? branch_target :
                                pc + ADDR_WIDTH'(1);
endmodule

// File: rtl/controle_pc.sv
// controle_pc: program counter with branch/jump selection, halt/resume and single-level interrupts
module controle_pc
  import pacote_processador::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int DATA_WIDTH = PC_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = 'h10
) (
  input logic         clock,
  input logic         reset,
  controle_pc_if.slave bus
);
  logic [ADDR_WIDTH-1:0] pc, pc_d, epc, epc_d, pc_inc, next_seq;
  logic [1:0]            estado, estado_d;
  logic                  irq_ack, ack_d;
  assign pc_inc = pc + ADDR_WIDTH'(1);
  assign bus.pc = pc;
  assign bus.pc_link = pc_inc;
  assign bus.epc = epc;
  assign bus.estado = estado;
  assign bus.irq_ack = irq_ack;
  seletor_destino #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sel (
    .pc(pc),
    .jalr(bus.jalr),
    .j_reg(bus.j_reg),
    .dado1(bus.dado1),
    .jump(bus.jump),
    .jump_addr(bus.jump_addr),
    .branch_taken(bus.branch_taken),
    .branch_target(bus.branch_target),
    .next_seq(next_seq)
  );
  // state and datapath registers; reset wins over stall and every state
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_ADDR;
      epc <= '0;
      estado <= EST_RUN;
      irq_ack <= 1'b0;
    end else begin
      pc <= pc_d;
      epc <= epc_d;
      estado <= estado_d;
      irq_ack <= ack_d;
    end
  end
  // next state: irq beats halt in RUN, wakes HALT, and is masked inside ISR
  always_comb begin
    estado_d = estado;
    if (!bus.stall)
      case (estado)
        EST_RUN:  estado_d = bus.irq ? EST_ISR : bus.halt ? EST_HALT : EST_RUN;
        EST_HALT: estado_d = bus.irq ? EST_ISR : bus.resume ? EST_RUN : EST_HALT;
        EST_ISR:  estado_d = bus.reti ? EST_RUN : EST_ISR;
        default:  estado_d = EST_RUN;
      endcase
  end
  // pc/epc/ack updates; the illegal encoding holds pc while recovering to RUN
  always_comb begin
    pc_d = pc;
    epc_d = epc;
    ack_d = 1'b0;
    if (!bus.stall)
      case (estado)
        EST_RUN: begin
          pc_d = bus.irq ? IRQ_VECTOR : bus.halt ? pc : next_seq;
          epc_d = bus.irq ? next_seq : epc;
          ack_d = bus.irq;
        end
        EST_HALT: begin
          pc_d = bus.irq ? IRQ_VECTOR : bus.resume ? pc_inc : pc;
          epc_d = bus.irq ? pc_inc : epc;
          ack_d = bus.irq;
        end
        EST_ISR: pc_d = bus.reti ? epc : next_seq;
        default: pc_d = pc;
      endcase
  end
endmodule
